// File: rtl/audio_mem_arbiter_pkg.sv
// Shared definitions for the audio memory arbiter: FSM encoding, grant codes,
// default timeout and round-robin helpers.
package audio_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_SPK  = 2'd1;
    localparam logic [1:0] GNT_MIC  = 2'd2;
    localparam logic [1:0] GNT_IO   = 2'd3;

    localparam int DEFAULT_TIMEOUT = 1023;

    // Requester that follows g in the spk -> mic -> io ring.
    function automatic logic [1:0] rr_next(input logic [1:0] g);
        logic [1:0] n;
        case (g)
            GNT_SPK: n = GNT_MIC;
            GNT_MIC: n = GNT_IO;
            default: n = GNT_SPK;
        endcase
        return n;
    endfunction

    // Request bit belonging to grant code g (bit0 spk, bit1 mic, bit2 io).
    function automatic logic req_of(input logic [2:0] req, input logic [1:0] g);
        logic r;
        case (g)
            GNT_SPK: r = req[0];
            GNT_MIC: r = req[1];
            GNT_IO:  r = req[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/audio_mem_arbiter_rr_pick3.sv
// Combinational round-robin picker over three requesters; the search begins at
// start_i (a grant code) and wraps spk -> mic -> io.
module rr_pick3
    import audio_mem_arbiter_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] start_i,
    output logic       vld_o,
    output logic [1:0] gnt_o
);

    logic [1:0] first;
    logic [1:0] second;
    logic [1:0] third;

    always_comb begin
        case (start_i)
            GNT_MIC: first = GNT_MIC;
            GNT_IO:  first = GNT_IO;
            default: first = GNT_SPK;
        endcase
        second = rr_next(first);
        third  = rr_next(second);

        vld_o = |req_i;
        gnt_o = GNT_NONE;
        if (req_of(req_i, first)) begin
            gnt_o = first;
        end else if (req_of(req_i, second)) begin
            gnt_o = second;
        end else if (req_of(req_i, third)) begin
            gnt_o = third;
        end
    end

endmodule

// File: rtl/audio_mem_arbiter.sv
// Shares one external memory between speaker (read), mic (write) and IO ports;
// one transaction in flight, round-robin arbitration, timeout abort.
module audio_mem_arbiter
    import audio_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int AW      = 24
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          spk_req_i,
    input  logic [AW-1:0] spk_addr_i,
    output logic          spk_ready_o,
    output logic [15:0]   spk_rdata_o,

    input  logic          mic_req_i,
    input  logic [AW-1:0] mic_addr_i,
    input  logic [15:0]   mic_wdata_i,
    output logic          mic_ready_o,

    input  logic          io_req_i,
    input  logic          io_we_i,
    input  logic [AW-1:0] io_addr_i,
    input  logic [15:0]   io_wdata_i,
    output logic          io_ready_o,
    output logic [15:0]   io_rdata_o,

    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [15:0]   mem_wdata_o,
    input  logic          mem_ready_i,
    input  logic [15:0]   mem_rdata_i,

    output logic [1:0]    grant_o,
    output logic          timeout_err_o
);

    localparam int            CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    grant_q, grant_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]   mem_wdata_q, mem_wdata_d;
    logic          spk_ready_q, spk_ready_d;
    logic          mic_ready_q, mic_ready_d;
    logic          io_ready_q, io_ready_d;
    logic [15:0]   spk_rdata_q, spk_rdata_d;
    logic [15:0]   io_rdata_q, io_rdata_d;
    logic          timeout_err_q, timeout_err_d;

    logic [2:0]    eff_req;
    logic          pick_vld;
    logic [1:0]    pick_gnt;

    // A port whose ready pulse is showing this cycle has not yet had the
    // chance to drop its request, so it is not eligible again yet.
    assign eff_req = {io_req_i  & ~io_ready_q,
                      mic_req_i & ~mic_ready_q,
                      spk_req_i & ~spk_ready_q};

    rr_pick3 u_pick (
        .req_i   (eff_req),
        .start_i (ptr_q),
        .vld_o   (pick_vld),
        .gnt_o   (pick_gnt)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        mem_req_d     = 1'b0;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        spk_ready_d   = 1'b0;
        mic_ready_d   = 1'b0;
        io_ready_d    = 1'b0;
        spk_rdata_d   = spk_rdata_q;
        io_rdata_d    = io_rdata_q;
        timeout_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant_d = GNT_NONE;
                if (pick_vld) begin
                    grant_d = pick_gnt;
                    ptr_d   = rr_next(pick_gnt);
                    state_d = ST_ISSUE;
                    case (pick_gnt)
                        GNT_SPK: begin
                            mem_addr_d  = spk_addr_i;
                            mem_we_d    = 1'b0;
                            mem_wdata_d = 16'h0000;
                        end
                        GNT_MIC: begin
                            mem_addr_d  = mic_addr_i;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = mic_wdata_i;
                        end
                        default: begin
                            mem_addr_d  = io_addr_i;
                            mem_we_d    = io_we_i;
                            mem_wdata_d = io_wdata_i;
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                mem_req_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion takes priority over an expiring counter.
                if (mem_ready_i) begin
                    case (grant_q)
                        GNT_SPK: begin
                            spk_ready_d = 1'b1;
                            spk_rdata_d = mem_rdata_i;
                        end
                        GNT_MIC: mic_ready_d = 1'b1;
                        GNT_IO: begin
                            io_ready_d = 1'b1;
                            io_rdata_d = mem_rdata_i;
                        end
                        default: ;
                    endcase
                    grant_d = GNT_NONE;
                    state_d = ST_IDLE;
                end else if (cnt_q == TMO) begin
                    timeout_err_d = 1'b1;
                    grant_d       = GNT_NONE;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                grant_d = GNT_NONE;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= GNT_SPK;
            cnt_q         <= '0;
            grant_q       <= GNT_NONE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            spk_ready_q   <= 1'b0;
            mic_ready_q   <= 1'b0;
            io_ready_q    <= 1'b0;
            spk_rdata_q   <= '0;
            io_rdata_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            spk_ready_q   <= spk_ready_d;
            mic_ready_q   <= mic_ready_d;
            io_ready_q    <= io_ready_d;
            spk_rdata_q   <= spk_rdata_d;
            io_rdata_q    <= io_rdata_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign spk_ready_o   = spk_ready_q;
    assign spk_rdata_o   = spk_rdata_q;
    assign mic_ready_o   = mic_ready_q;
    assign io_ready_o    = io_ready_q;
    assign io_rdata_o    = io_rdata_q;
    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign grant_o       = grant_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_audio_mem_arbiter.sv
// Directed bench for audio_mem_arbiter with TIMEOUT=15; cycle n is observed
// 1 time unit after rising edge n.
module tb_audio_mem_arbiter;

    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          spk_req, mic_req, io_req, io_we;
    logic [AW-1:0] spk_addr, mic_addr, io_addr;
    logic [15:0]   mic_wdata, io_wdata;
    logic          spk_ready, mic_ready, io_ready;
    logic [15:0]   spk_rdata, io_rdata;
    logic          mem_req, mem_we, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata, mem_rdata;
    logic [1:0]    grant;
    logic          timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    audio_mem_arbiter #(.TIMEOUT(15), .AW(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .spk_req_i     (spk_req),
        .spk_addr_i    (spk_addr),
        .spk_ready_o   (spk_ready),
        .spk_rdata_o   (spk_rdata),
        .mic_req_i     (mic_req),
        .mic_addr_i    (mic_addr),
        .mic_wdata_i   (mic_wdata),
        .mic_ready_o   (mic_ready),
        .io_req_i      (io_req),
        .io_we_i       (io_we),
        .io_addr_i     (io_addr),
        .io_wdata_i    (io_wdata),
        .io_ready_o    (io_ready),
        .io_rdata_o    (io_rdata),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_ready_i   (mem_ready),
        .mem_rdata_i   (mem_rdata),
        .grant_o       (grant),
        .timeout_err_o (timeout_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; spk_req = 1'b1; mem_ready = 1'b1; mem_rdata = 16'hFFFF;
        step(); step();
        total++;
        if ({mem_req, mem_we, grant, timeout_err, spk_ready, mic_ready, io_ready} !== 8'h00) begin
            bad++; $display("FAIL reset_ctrl_during: got %b want 00000000",
                            {mem_req, mem_we, grant, timeout_err, spk_ready, mic_ready, io_ready});
        end
        total++;
        if (mem_addr !== 24'h0 || mem_wdata !== 16'h0) begin
            bad++; $display("FAIL reset_mem_bus: addr=%h wdata=%h want 0", mem_addr, mem_wdata);
        end
        total++;
        if (spk_rdata !== 16'h0 || io_rdata !== 16'h0) begin
            bad++; $display("FAIL reset_rdata: spk=%h io=%h want 0", spk_rdata, io_rdata);
        end
        spk_req = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0; reset = 1'b0;
        step(); step();
        total++;
        if ({mem_req, grant, timeout_err, spk_ready} !== 5'b0) begin
            bad++; $display("FAIL reset_after: got %b want 00000", {mem_req, grant, timeout_err, spk_ready});
        end
    endtask

    task automatic test_spk_read();
        spk_req = 1'b1; spk_addr = 24'h000010;
        step();                                        // cycle 1
        total++;
        if (grant !== 2'd1 || mem_req !== 1'b0) begin
            bad++; $display("FAIL spk_issue: grant=%0d mem_req=%b want 1/0", grant, mem_req);
        end
        step();                                        // cycle 2
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 24'h000010 || mem_we !== 1'b0) begin
            bad++; $display("FAIL spk_memreq: req=%b addr=%h we=%b want 1/000010/0", mem_req, mem_addr, mem_we);
        end
        step();                                        // cycle 3
        total++;
        if (mem_req !== 1'b0 || grant !== 2'd1) begin
            bad++; $display("FAIL spk_wait: req=%b grant=%0d want 0/1", mem_req, grant);
        end
        step(); step();                                // cycle 5
        mem_ready = 1'b1; mem_rdata = 16'hBEEF;
        step();                                        // cycle 6
        mem_ready = 1'b0;
        total++;
        if (spk_ready !== 1'b1 || spk_rdata !== 16'hBEEF || grant !== 2'd0) begin
            bad++; $display("FAIL spk_done: ready=%b rdata=%h grant=%0d want 1/BEEF/0", spk_ready, spk_rdata, grant);
        end
        spk_req = 1'b0;
        step();                                        // cycle 7
        total++;
        if (spk_ready !== 1'b0 || spk_rdata !== 16'hBEEF) begin
            bad++; $display("FAIL spk_pulse: ready=%b rdata=%h want 0/BEEF", spk_ready, spk_rdata);
        end
    endtask

    task automatic test_mic_write();
        mic_req = 1'b1; mic_addr = 24'h000020; mic_wdata = 16'h1234;
        step();
        total++;
        if (grant !== 2'd2) begin
            bad++; $display("FAIL mic_grant_issue: grant=%0d want 2", grant);
        end
        step();
        total++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'h1234 ||
            mem_addr !== 24'h000020 || grant !== 2'd2) begin
            bad++; $display("FAIL mic_memreq: req=%b we=%b wdata=%h addr=%h grant=%0d want 1/1/1234/000020/2",
                            mem_req, mem_we, mem_wdata, mem_addr, grant);
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        total++;
        if (mic_ready !== 1'b1 || spk_ready !== 1'b0 || io_ready !== 1'b0) begin
            bad++; $display("FAIL mic_done: mic=%b spk=%b io=%b want 1/0/0", mic_ready, spk_ready, io_ready);
        end
        mic_req = 1'b0;
        step();
        total++;
        if (mic_ready !== 1'b0) begin
            bad++; $display("FAIL mic_pulse: mic_ready=%b want 0", mic_ready);
        end
    endtask

    task automatic test_round_robin();
        spk_req = 1'b1; mic_req = 1'b1; io_req = 1'b1; io_we = 1'b0;
        spk_addr = 24'h000100; mic_addr = 24'h000200; io_addr = 24'h000300;
        apply_reset(2);
        for (int i = 0; i < 6; i++) begin
            int         w;
            logic [1:0] exp_g;
            logic [15:0] exp_rd;
            logic       ok;
            exp_g  = 2'((i % 3) + 1);
            exp_rd = 16'hA000 + 16'(i);
            w = 0;
            while (grant === 2'd0 && w < 10) begin step(); w++; end
            total++;
            if (grant !== exp_g) begin
                bad++; $display("FAIL rr_grant[%0d]: grant=%0d want %0d", i, grant, exp_g);
            end
            w = 0;
            while (mem_req !== 1'b1 && w < 10) begin step(); w++; end
            mem_ready = 1'b1; mem_rdata = exp_rd;
            step();
            mem_ready = 1'b0;
            case (exp_g)
                2'd1:    ok = (spk_ready === 1'b1) && (spk_rdata === exp_rd);
                2'd2:    ok = (mic_ready === 1'b1);
                default: ok = (io_ready === 1'b1) && (io_rdata === exp_rd);
            endcase
            total++;
            if (!ok) begin
                bad++; $display("FAIL rr_done[%0d]: rdy=%b%b%b spk=%h io=%h want owner %0d data %h",
                                i, spk_ready, mic_ready, io_ready, spk_rdata, io_rdata, exp_g, exp_rd);
            end
        end
        spk_req = 1'b0; mic_req = 1'b0; io_req = 1'b0;
        step();
    endtask

    task automatic test_io_write();
        io_req = 1'b1; io_we = 1'b1; io_addr = 24'h000040; io_wdata = 16'h5A5A;
        step();
        total++;
        if (grant !== 2'd3) begin
            bad++; $display("FAIL io_grant: grant=%0d want 3", grant);
        end
        step();
        total++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 24'h000040 || mem_wdata !== 16'h5A5A) begin
            bad++; $display("FAIL io_memreq: req=%b we=%b addr=%h wdata=%h want 1/1/000040/5A5A",
                            mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ready = 1'b1; mem_rdata = 16'hDEAD;
        step();
        mem_ready = 1'b0;
        total++;
        if (io_ready !== 1'b1 || io_rdata !== 16'hDEAD || spk_rdata !== 16'hA003) begin
            bad++; $display("FAIL io_done: ready=%b io_rdata=%h spk_rdata=%h want 1/DEAD/A003",
                            io_ready, io_rdata, spk_rdata);
        end
        io_req = 1'b0; io_we = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        logic seen;
        spk_req = 1'b1; mic_req = 1'b1; spk_addr = 24'h000050;
        apply_reset(1);
        step(); step();                                // cycle 2
        total++;
        if (mem_req !== 1'b1 || grant !== 2'd1) begin
            bad++; $display("FAIL to_memreq: req=%b grant=%0d want 1/1", mem_req, grant);
        end
        seen = 1'b0;
        for (int c = 3; c <= 17; c++) begin
            step();
            if (timeout_err !== 1'b0 || spk_ready !== 1'b0 || mic_ready !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL to_early: early timeout or ready seen=%b want 0", seen);
        end
        step();                                        // cycle 18
        total++;
        if (timeout_err !== 1'b1 || spk_ready !== 1'b0 || grant !== 2'd0) begin
            bad++; $display("FAIL to_pulse: err=%b spk_ready=%b grant=%0d want 1/0/0", timeout_err, spk_ready, grant);
        end
        spk_req = 1'b0;
        step();                                        // cycle 19
        total++;
        if (timeout_err !== 1'b0 || grant !== 2'd2) begin
            bad++; $display("FAIL to_next: err=%b grant=%0d want 0/2", timeout_err, grant);
        end
        step();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        total++;
        if (mic_ready !== 1'b1) begin
            bad++; $display("FAIL to_mic_done: mic_ready=%b want 1", mic_ready);
        end
        mic_req = 1'b0;
        step();
    endtask

    task automatic test_timeout_edge();
        spk_req = 1'b1; spk_addr = 24'h000060;
        step(); step();                                // cycle 2
        repeat (15) step();                            // cycle 17
        mem_ready = 1'b1; mem_rdata = 16'h7777;
        step();
        mem_ready = 1'b0;
        total++;
        if (spk_ready !== 1'b1 || timeout_err !== 1'b0 || spk_rdata !== 16'h7777) begin
            bad++; $display("FAIL to_edge: ready=%b err=%b rdata=%h want 1/0/7777", spk_ready, timeout_err, spk_rdata);
        end
        spk_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        io_req = 1'b1; io_we = 1'b0; io_addr = 24'h000030;
        step(); step(); step();                        // cycle 3, waiting
        reset = 1'b1; io_req = 1'b0;
        step();
        total++;
        if ({mem_req, mem_we, grant, io_ready, timeout_err} !== 6'b0 || mem_addr !== 24'h0 ||
            io_rdata !== 16'h0 || spk_rdata !== 16'h0) begin
            bad++; $display("FAIL rst_mid: ctrl=%b addr=%h io=%h spk=%h want 0",
                            {mem_req, mem_we, grant, io_ready, timeout_err}, mem_addr, io_rdata, spk_rdata);
        end
        reset = 1'b0;
        step();
        mem_ready = 1'b1; mem_rdata = 16'h4444;
        step();
        mem_ready = 1'b0;
        total++;
        if ({spk_ready, mic_ready, io_ready, grant, mem_req} !== 6'b0 || io_rdata !== 16'h0) begin
            bad++; $display("FAIL rst_late_ready: ctrl=%b io_rdata=%h want 0",
                            {spk_ready, mic_ready, io_ready, grant, mem_req}, io_rdata);
        end
    endtask

    task automatic test_idle_ready();
        mem_ready = 1'b1; mem_rdata = 16'h9999;
        step(); step();
        mem_ready = 1'b0;
        total++;
        if ({spk_ready, mic_ready, io_ready, grant, mem_req, timeout_err} !== 7'b0 || spk_rdata !== 16'h0) begin
            bad++; $display("FAIL idle_ready: ctrl=%b spk_rdata=%h want 0",
                            {spk_ready, mic_ready, io_ready, grant, mem_req, timeout_err}, spk_rdata);
        end
        spk_req = 1'b1; spk_addr = 24'h000070;
        step();
        total++;
        if (grant !== 2'd1 || mem_req !== 1'b0) begin
            bad++; $display("FAIL idle_after_issue: grant=%0d req=%b want 1/0", grant, mem_req);
        end
        step();
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 24'h000070) begin
            bad++; $display("FAIL idle_after_memreq: req=%b addr=%h want 1/000070", mem_req, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 16'h0101;
        step();
        mem_ready = 1'b0; spk_req = 1'b0;
        total++;
        if (spk_ready !== 1'b1 || spk_rdata !== 16'h0101) begin
            bad++; $display("FAIL idle_after_done: ready=%b rdata=%h want 1/0101", spk_ready, spk_rdata);
        end
        step();
    endtask

    initial begin
        reset = 1'b1;
        spk_req = 1'b0; mic_req = 1'b0; io_req = 1'b0; io_we = 1'b0;
        spk_addr = '0; mic_addr = '0; io_addr = '0;
        mic_wdata = '0; io_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        step();
        test_reset();
        test_spk_read();
        test_mic_write();
        test_round_robin();
        test_io_write();
        test_timeout();
        test_timeout_edge();
        test_reset_mid();
        test_idle_ready();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1);
    end

endmodule
